// File: rtl/rr_arbiter4_pkg.sv
// arb_pkg: shared state encoding, sizes and reset rotation origin for rr_arbiter4
package arb_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
    localparam int ARB_N = 4;
    localparam int ARB_IDX_W = 2;
    localparam logic [ARB_IDX_W-1:0] LAST_RST = 2'd3;
endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/release inputs and registered grant outputs of the arbiter
interface rr_arbiter4_if;
    import arb_pkg::*;
    logic [ARB_N-1:0] req;
    logic done;
    logic gnt_valid;
    logic a;
    logic b;
    logic timeout;
    modport slave (input req, done, output gnt_valid, a, b, timeout);
    modport master (output req, done, input gnt_valid, a, b, timeout);
endinterface

// File: rtl/rr_arbiter4_pick4.sv
// rr_pick4: combinational round-robin search starting just after last, last itself lowest
module rr_pick4
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] last,
    output logic [ARB_IDX_W-1:0] idx,
    output logic                 any
);
    // scan from farthest to nearest so the nearest asserted requester wins
    always_comb begin
        idx = last + 2'd1;
        any = |req;
        for (int k = ARB_N; k >= 1; k--)
            if (req[last + 2'(k)]) idx = last + 2'(k);
    end
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with held grants; ARB_TIMEOUT_EN adds a forced-release watchdog
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input logic         clk,
    input logic         rst,
    rr_arbiter4_if.slave bus
);
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 2..255");
    end
    arb_state_e            state_q;
    logic [ARB_IDX_W-1:0]  idx_q, last_q, pick_idx;
    logic                  gv_q, pick_any, force_rel, rel;
    rr_pick4 u_pick (
        .req  (bus.req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );
    assign rel = bus.done | force_rel;
`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       timeout_q;
    assign force_rel = state_q == GRANT && hold_q == 8'(MAX_HOLD - 1);
    // hold counter restarts with every new grant; timeout marks a forced, not a normal, release
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= (state_q == GRANT && !rel) ? hold_q + 8'd1 : 8'd0;
            timeout_q <= force_rel && !bus.done;
        end
    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif
    // grant FSM: latch winner from idle, hold until release, re-arbitrate with no bubble
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= LAST_RST;
            gv_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (pick_any) begin
                state_q <= GRANT;
                idx_q   <= pick_idx;
                last_q  <= pick_idx;
                gv_q    <= 1'b1;
            end
        end else if (rel) begin
            if (pick_any) begin
                idx_q  <= pick_idx;
                last_q <= pick_idx;
            end else begin
                state_q <= IDLE;
                gv_q    <= 1'b0;
            end
        end
    assign bus.gnt_valid = gv_q;
    assign bus.a         = idx_q[1];
    assign bus.b         = idx_q[0];
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that produces a registered 2-bit grant index on `a`/`b`, feeding the 2-to-4 decoder directly. The decoder turns this index into the one-hot enables. The block owns grant fairness, grant hold until release, and an optional forced-release watchdog. It sits directly upstream of the decoder in the channel-select path.

## Interface
- `MAX_HOLD`, default 8: maximum cycles a grant is held before forced release. Range 2..255. Used only when `ARB_TIMEOUT_EN` is defined.

- `clk`  input  1  — single clock; all state changes on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `req`  input  4  — request vector; bit i = requester i.
- `done`  input  1  — the current grant holder releases the grant.
- `gnt_valid`  output  1  — `a`/`b` hold a valid grant.
- `a`  output  1  — grant index MSB (idx[1]); connects to decoder input `a`.
- `b`  output  1  — grant index LSB (idx[0]); connects to decoder input `b`.
- `timeout`  output  1  — one-cycle pulse when a grant is force-released.

## Operation
- The FSM has two states, IDLE and GRANT.
- **Reset:**
  - State → IDLE.
  - `gnt_valid`=0, `a`=0, `b`=0, `timeout`=0.
  - `last`=3, so requester 0 has the highest priority first.
- **Priority:** search order is `last+1`, `last+2`, `last+3`, `last`, all mod 4. The first asserted `req` bit wins.
- **IDLE:**
  - If `req`≠0: latch the winner into `{a,b}`, set `last`=winner, assert `gnt_valid`, go to GRANT.
  - Otherwise remain in IDLE.
- **GRANT:**
  - `{a,b}` and `gnt_valid` stay stable until release. A release is `done`=1, or a timeout when enabled.
  - `req` changes during GRANT, including the holder dropping its bit, do not alter the grant.
- **Release with `req`≠0:** the next winner is computed from `req` in the release cycle, with the just-released index lowest priority. The new index is loaded the next cycle and `gnt_valid` stays 1 (zero bubble).
  - A holder that is still requesting is granted again only if no other bit is set.
- **Release with `req`=0:** go to IDLE and drop `gnt_valid` the next cycle. `{a,b}` keep their last value.
- **`done` outside GRANT:** ignored.
- **Reset mid-grant:** takes effect immediately (asynchronous). The grant is lost and the rotation restarts from requester 0.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge N gives `gnt_valid`/`a`/`b` valid after edge N.
- Release-to-next-grant latency is 1 cycle, with no idle cycle in between.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `timeout` is high exactly for the cycle in which the forced re-arbitration result appears.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on each new grant and increments every GRANT cycle.
  - When the count reaches `MAX_HOLD`-1 without `done`, the release is forced exactly as if `done`=1, and `timeout` pulses.
  - If `done` arrives in the same cycle as the limit, it counts as a normal release and `timeout` stays 0.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built; `timeout` is tied to 0.
  - A grant is held indefinitely until `done`.

## Structure
- Shared package `arb_pkg` contains:
  - the state enum, IDLE=1'b0 and GRANT=1'b1;
  - `ARB_N`=4 and `ARB_IDX_W`=2;
  - the reset value of `last` (2'd3).
- One sub-module, `rr_pick4`: purely combinational. Inputs are `req[3:0]` and `last[1:0]`; outputs are `idx[1:0]` and `any`. It is used for both the IDLE and release paths.

## Test plan
- **Reset:** assert `rst` mid-grant with `{a,b}`=2'b10.
  - Outputs go to 0 immediately.
  - After release, `req`=4'b1111 yields idx 0 on the next edge.
- **Rotation:** hold `req`=4'b1111 and pulse `done` each cycle. Grants must sequence 0,1,2,3,0, with `gnt_valid` continuously 1.
- **Fairness skip:** grant idx 1, then set `req`=4'b0011 and release. The next grant is idx 0, not 1.
- **Hold:** grant idx 2, then drop `req[2]` and raise `req[3]` without `done`. `{a,b}` stays 2'b10 for 10 cycles.
- **Empty release:** release with `req`=0.
  - `gnt_valid` falls the next cycle.
  - A later `req`=4'b0100 gives idx 2 one cycle after it is sampled.
- **Timeout (macro defined, `MAX_HOLD`=4):** hold `req`=4'b0011 with no `done` after granting idx 0.
  - Idx 1 is granted 4 cycles after the grant.
  - `timeout` pulses once.
  - With `done` on the limit cycle, `timeout` stays 0.
